// File: rtl/hazard_ctrl.sv
// Scoreboard-style RAW/WAW interlock for a single-issue pipe with fixed write-back latency.
// Tracks in-flight destinations in a WB_LAT-deep shift pipeline and stalls decode on conflicts.
module hazard_ctrl #(
  parameter int unsigned WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic        rarf,
  input  logic        rbrf,
  input  logic        rawf,
  input  logic        rbwf,
  input  logic        flush,
  output logic        id_ready,
  output logic        issue,
  output logic        iss_wen,
  output logic [2:0]  iss_wdst,
  output logic [7:0]  busy_mask,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [2:0] d;
  } slot_t;

  slot_t slots [WB_LAT];

  logic [2:0] ra, rb, dst;
  logic       wr, hazard;

  assign ra  = id_instr[13:11];
  assign rb  = id_instr[10:8];
  assign wr  = rawf | rbwf;
  assign dst = rawf ? ra : rb;

  always_comb begin
    busy_mask = '0;
    for (int unsigned k = 0; k < WB_LAT; k++) begin
      if (slots[k].v) busy_mask[slots[k].d] = 1'b1;
    end
  end

  assign hazard   = (rarf & busy_mask[ra]) | (rbrf & busy_mask[rb]) | (wr & busy_mask[dst]);
  assign id_ready = ~hazard & ~flush & ~rst;
  assign issue    = id_valid & id_ready;
  assign iss_wen  = issue & wr;
  assign iss_wdst = iss_wen ? dst : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < WB_LAT; k++) slots[k] <= '0;
      stall_cnt <= '0;
    end else begin
      // A flush kills the instruction currently in s1, so it must not reach s2.
      for (int unsigned k = 1; k < WB_LAT; k++) begin
        slots[k].v <= (k == 1 && flush) ? 1'b0 : slots[k-1].v;
        slots[k].d <= slots[k-1].d;
      end
      slots[0].v <= issue & wr;
      slots[0].d <= dst;
      if (id_valid & hazard & ~flush & (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a per-register countdown model checked every cycle.
module tb_hazard_ctrl;

  localparam int WB_LAT = 3;

  logic        clk = 1'b0;
  logic        rst, id_valid, rarf, rbrf, rawf, rbwf, flush;
  logic [15:0] id_instr;
  logic        id_ready, issue, iss_wen;
  logic [2:0]  iss_wdst;
  logic [7:0]  busy_mask;
  logic [15:0] stall_cnt;

  hazard_ctrl #(.WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .rarf(rarf), .rbrf(rbrf), .rawf(rawf), .rbwf(rbwf), .flush(flush),
    .id_ready(id_ready), .issue(issue), .iss_wen(iss_wen), .iss_wdst(iss_wdst),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each register carries the number of cycles its pending write is still outstanding.
  int          pend [8];
  logic        last_v = 1'b0;
  logic [2:0]  last_r = '0;
  int          cnt_m  = 0;

  initial for (int r = 0; r < 8; r++) pend[r] = 0;

  function automatic logic [2:0] m_dst();
    return rawf ? id_instr[13:11] : id_instr[10:8];
  endfunction

  function automatic logic m_hz();
    logic [2:0] a, b;
    a = id_instr[13:11];
    b = id_instr[10:8];
    return (rarf && pend[a] > 0) || (rbrf && pend[b] > 0) ||
           ((rawf || rbwf) && pend[m_dst()] > 0);
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] m;
    m = '0;
    for (int r = 0; r < 8; r++) if (pend[r] > 0) m[r] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    logic hz, iss, w;
    logic [2:0] d;
    if (rst) begin
      for (int r = 0; r < 8; r++) pend[r] = 0;
      cnt_m  = 0;
      last_v = 1'b0;
    end else begin
      hz  = m_hz();
      w   = rawf | rbwf;
      d   = m_dst();
      iss = id_valid && !hz && !flush;
      if (id_valid && hz && !flush && cnt_m < 65535) cnt_m++;
      for (int r = 0; r < 8; r++) if (pend[r] > 0) pend[r]--;
      if (flush && last_v) pend[last_r] = 0;
      if (iss && w) begin
        pend[d] = WB_LAT;
        last_v  = 1'b1;
        last_r  = d;
      end else begin
        last_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic rdy_m, iss_m, wen_m;
    if (chk_en) begin
      rdy_m = !m_hz() && !flush && !rst;
      iss_m = id_valid && rdy_m;
      wen_m = iss_m && (rawf || rbwf);
      chk("m_id_ready", 32'(id_ready), 32'(rdy_m));
      chk("m_issue", 32'(issue), 32'(iss_m));
      chk("m_iss_wen", 32'(iss_wen), 32'(wen_m));
      chk("m_iss_wdst", 32'(iss_wdst), wen_m ? 32'(m_dst()) : 32'd0);
      chk("m_busy_mask", 32'(busy_mask), 32'(m_busy()));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(cnt_m));
    end
  end

  task automatic drv(input logic v, input logic [15:0] ins, input logic [3:0] fl, input logic f);
    id_valid = v;
    id_instr = ins;
    {rarf, rbrf, rawf, rbwf} = fl;
    flush = f;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(1'b1, 16'hCA00, 4'b1101, 1'b0);
    @(negedge clk);
    if (chk_en) begin
      chk("rst_ready", 32'(id_ready), 32'd0);
      chk("rst_issue", 32'(issue), 32'd0);
    end
    next();
    chk_en = 1'b1;
    rst = 1'b0;
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_wdst", 32'(iss_wdst), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    next();
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    #1;
    do_reset();

    // RAW: CA00 writes r2, D300 reads r2
    drv(1'b1, 16'hCA00, 4'b1101, 1'b0);
    @(negedge clk);
    chk("raw_first_issue", 32'(issue), 32'd1);
    chk("raw_first_wdst", 32'(iss_wdst), 32'd2);
    next();
    for (int c = 1; c <= 3; c++) begin
      drv(1'b1, 16'hD300, 4'b1100, 1'b0);
      @(negedge clk);
      chk("raw_ready", 32'(id_ready), 32'd0);
      chk("raw_busy", 32'(busy_mask), 32'h04);
      next();
    end
    @(negedge clk);
    chk("raw_issue4", 32'(issue), 32'd1);
    chk("raw_cnt", 32'(stall_cnt), 32'd3);
    next();
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    next();

    // Independent back-to-back
    do_reset();
    drv(1'b1, 16'hCA00, 4'b1101, 1'b0);
    @(negedge clk); chk("ind_issue0", 32'(issue), 32'd1); next();
    drv(1'b1, 16'hE000, 4'b1100, 1'b0);
    @(negedge clk); chk("ind_issue1", 32'(issue), 32'd1); next();
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    @(negedge clk); chk("ind_cnt", 32'(stall_cnt), 32'd0); next();

    // Both write flags: ra wins
    drv(1'b1, 16'h0A00, 4'b0011, 1'b0);
    @(negedge clk); chk("both_wdst", 32'(iss_wdst), 32'd1); next();
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) next();

    // NOP stream
    for (int c = 0; c < 10; c++) begin
      drv(1'b1, 16'h0000, 4'b0000, 1'b0);
      @(negedge clk);
      chk("nop_issue", 32'(issue), 32'd1);
      chk("nop_busy", 32'(busy_mask), 32'd0);
      next();
    end

    // Flush kills the youngest in-flight writer
    do_reset();
    drv(1'b1, 16'hCA00, 4'b1101, 1'b0);
    @(negedge clk); next();
    drv(1'b1, 16'hD300, 4'b1100, 1'b1);
    @(negedge clk); chk("fl_issue1", 32'(issue), 32'd0); next();
    drv(1'b1, 16'hD300, 4'b1100, 1'b0);
    @(negedge clk);
    chk("fl_busy2", 32'(busy_mask), 32'd0);
    chk("fl_issue2", 32'(issue), 32'd1);
    next();
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) next();

    // Reset mid-stall
    do_reset();
    drv(1'b1, 16'hCA00, 4'b1101, 1'b0);
    next();
    drv(1'b1, 16'hD300, 4'b1100, 1'b0);
    next();
    rst = 1'b1;
    @(negedge clk); chk("rms_ready", 32'(id_ready), 32'd0); next();
    rst = 1'b0;
    @(negedge clk);
    chk("rms_issue", 32'(issue), 32'd1);
    chk("rms_busy", 32'(busy_mask), 32'd0);
    chk("rms_cnt", 32'(stall_cnt), 32'd0);
    next();
    drv(1'b0, 16'h0000, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) next();

    // Saturation: r2 read+write self-dependency stalls 3 of every 4 cycles
    do_reset();
    drv(1'b1, 16'h1000, 4'b1010, 1'b0);
    @(negedge clk); chk("self_dep_issue", 32'(issue), 32'd1); next();
    for (int c = 0; c < 88000; c++) next();
    @(negedge clk); chk("sat_cnt", 32'(stall_cnt), 32'hFFFF); next();
    next();
    @(negedge clk); chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter WB_LAT, default 3, giving the number of cycles from issue to register-file write-back (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port id_valid, input, 1 bit: the decode stage presents an instruction.
REQ-005 The block SHALL have port id_instr, input, 16 bits: the instruction at decode; ra = id_instr[13:11], rb = id_instr[10:8].
REQ-006 The block SHALL have ports rarf, rbrf, rawf, rbwf, input, 1 bit each: the read-ra, read-rb, write-ra and write-rb flags from the instruction read/write flag decoder for id_instr.
REQ-007 The block SHALL have port flush, input, 1 bit: a taken branch kills the youngest in-flight instruction and the decode instruction.
REQ-008 The block SHALL have port id_ready, output, 1 bit: the decode instruction may issue this cycle.
REQ-009 The block SHALL have port issue, output, 1 bit: equal to id_valid & id_ready.
REQ-010 The block SHALL have port iss_wen, output, 1 bit, and port iss_wdst, output, 3 bits: the write enable and destination register of the issuing instruction.
REQ-011 The block SHALL have port busy_mask, output, 8 bits: bit n set while register n has a pending write.
REQ-012 The block SHALL have port stall_cnt, output, 16 bits: the saturating count of hazard stall cycles.

Function
REQ-013 The block SHALL hold a shift pipeline of WB_LAT slots, s1 (youngest) to sN (oldest), each holding {valid, dst[2:0]}.
REQ-014 The block SHALL take the write destination as ra if rawf=1, else rb if rbwf=1; the instruction writes if rawf|rbwf, and rawf wins if both flags are set.
REQ-015 The block SHALL compute busy_mask combinationally as the OR of one-hot(dst) over all valid slots.
REQ-016 The block SHALL flag a hazard when (rarf & busy_mask[ra]) | (rbrf & busy_mask[rb]) | (write & busy_mask[dst]).
REQ-017 The block SHALL drive id_ready = ~hazard & ~flush & ~rst, combinationally.
REQ-018 On each clock edge the block SHALL shift the slots, with sN discarded, s(k+1)<=s(k), and s1<={issue & write, dst}.
REQ-019 When flush=1 the block SHALL load s1 with invalid, shift the older slots normally, and suppress issue in the same cycle.
REQ-020 The block SHALL clear a register's busy bit in the cycle after its slot leaves sN, so WB_LAT stall cycles is the maximum for a back-to-back dependency.
REQ-021 An instruction with all four flags 0 (e.g. 0x0000 NOP) SHALL never stall and SHALL occupy no valid slot.
REQ-022 The block SHALL drive iss_wen = issue & write and iss_wdst = dst, with iss_wdst = 0 when iss_wen = 0.
REQ-023 The block SHALL increment stall_cnt on each cycle with id_valid & hazard & ~flush, saturating at 0xFFFF.
REQ-024 A self-dependency on a register written by the same instruction SHALL not stall, because only in-flight slots are checked.
REQ-025 When id_valid=0, flags SHALL be don't-care and stall_cnt SHALL not change.

Reset
REQ-026 While rst=1 the block SHALL invalidate all slots, clear stall_cnt to 0 and force id_ready=0 and issue=0.
REQ-027 After reset, busy_mask, iss_wen and iss_wdst SHALL read 0.
REQ-028 A reset asserted mid-stall SHALL discard pending writes, so on the first cycle after rst deasserts a waiting instruction issues with id_ready=1.

Verification (WB_LAT=3)
REQ-029 RAW: issue 0xCA00 (rarf, rbrf, rbwf) at cycle 0, then hold 0xD300 (rarf, rbrf) valid -> id_ready=0 in cycles 1-3, issue in cycle 4, stall_cnt=3, busy_mask=0x04 in cycles 1-3.
REQ-030 Independent: 0xCA00, then 0xE000 (ra=4, rb=0, reads only) -> both issue back-to-back, stall_cnt=0.
REQ-031 NOP stream: 0x0000 with all flags 0 for 10 cycles -> issue=1 every cycle, busy_mask=0.
REQ-032 Flush: issue 0xCA00 at cycle 0, flush=1 at cycle 1 -> busy_mask=0x00 from cycle 2, the next dependent instruction issues at cycle 2, and issue=0 at cycle 1.
REQ-033 Saturation: hold a hazard for 70000 cycles -> stall_cnt stays at 0xFFFF.
REQ-034 Reset mid-stall: rst=1 at cycle 2 of REQ-029 -> stall_cnt=0 and busy_mask=0 after reset, and 0xD300 issues on the first cycle with rst=0.
